sm4_axis128_egress: RTL and testbench
=====================================

Name: sm4_axis128_egress

Overview:
- Egress side of the 128-bit AXI-Stream SM4 datapath.
- The SM4 AXIS wrapper emits results with no backpressure, at a fixed pipeline latency of about 32 cycles. This block buffers those results in a FIFO and presents a full AXIS master with tready to the downstream consumer.
- It also returns a credit signal that the ingress side ANDs into s_axis_tready. Blocks are admitted only when buffer space is guaranteed, so results are never dropped.

Parameters:
- DEPTH, 64, FIFO entries; must be a power of two and at least 40 (32 pipeline + 8 margin) for full throughput.
- AW, 6, log2(DEPTH); pointer width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear; pulse alongside sm4_vld on key/mode reload.
- in_fire  in  1  ingress handshake (s_axis_tvalid & s_axis_tready); one block entered the core.
- res_tvalid  in  1  core result valid (wrapper m_axis_tvalid).
- res_tdata  in  128  core result data.
- res_tlast  in  1  core result last.
- m_axis_tdata  out  128  buffered result.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tlast  out  1  tlast stored with the head entry.
- m_axis_tready  in  1  downstream ready.
- credit_ok  out  1  high when outstanding < DEPTH; ingress may accept a block.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- outstanding  out  AW+1  blocks admitted and not yet popped (in flight plus stored).
- overflow  out  1  sticky error: a result arrived while the FIFO was full.

Behaviour:
- Reset (async, rst=1): pointers 0; level=0; outstanding=0; overflow=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; credit_ok=1.
- Storage: DEPTH x 129-bit register array holding {tlast, tdata}.
  - write: wr_ptr advances on res_tvalid when not full.
  - pop: m_axis_tvalid & m_axis_tready; rd_ptr advances.
  - Pointers are AW+1 bits and wrap modulo 2*DEPTH.
  - full = (level == DEPTH); empty = (level == 0).
- First-word fall-through:
  - m_axis_tdata/m_axis_tlast = mem[rd_ptr] combinationally; m_axis_tvalid = !empty.
  - A result written in cycle N is visible at the output in cycle N+1.
- AXIS rule: once m_axis_tvalid=1, tdata and tlast stay stable until pop. Only a pop or flush changes the head.
- level update per cycle:
  - write only: +1.
  - pop only: -1.
  - both: unchanged. A write while full is permitted when a pop occurs in the same cycle.
- Overflow: res_tvalid while full with no pop in the same cycle.
  - The data is dropped and overflow is set; overflow clears only on rst.
  - Unreachable if ingress honours credit_ok; the bench treats any set as a failure.
- outstanding update per cycle:
  - in_fire only: +1.
  - pop only: -1.
  - both: unchanged. Saturates at DEPTH and at 0 (no wrap).
- credit_ok = (outstanding < DEPTH), from registered state. When outstanding == DEPTH-1 and in_fire occurs, credit_ok drops the next cycle.
- flush (synchronous, higher priority than write/pop):
  - next cycle: pointers 0, level=0, outstanding=0, m_axis_tvalid=0.
  - overflow is kept.
  - Results still in the core pipeline are discarded by the wrapper's reload sequence, which lasts more than 32 cycles, so no stale result reaches the FIFO.
- No reordering or modification of data; tlast travels with its word.
- Latency: res_tvalid to m_axis_tvalid is 1 cycle when the FIFO is empty.

Decomposition:
- Shared package sm4_pkg: SM4_BLK_W=128, SM4_PIPE_LAT=32, SM4_EGRESS_MARGIN=8.
- One natural sub-module, sm4_fifo_fwft: generic synchronous FWFT FIFO with parameters W and AW, ports wr/rd/full/empty/level and flush.
- Credit counter and overflow flag remain in the top module.

Test Plan:
- Reset then idle -> m_axis_tvalid=0, level=0, outstanding=0, credit_ok=1, overflow=0.
- 10 in_fire pulses; after 32 cycles, 10 results (data 0x1..0xA, last on 0xA) with m_axis_tready=1 -> outputs appear in order, each 1 cycle after write; outstanding returns to 0; tlast only on 0xA.
- m_axis_tready=0, 64 in_fire pulses, 64 results -> credit_ok drops the cycle after the 64th in_fire; level=64; no overflow. Then tready=1 for 64 cycles -> all 64 popped in order, level=0.
- FIFO full, simultaneous res_tvalid and pop -> level stays 64, the new word is stored, overflow=0.
- FIFO full, m_axis_tready=0, force one extra res_tvalid -> overflow=1 and stays set through the subsequent drain; stored contents unchanged.
- Mid-stream flush with level=5 and outstanding=12 -> next cycle level=0, outstanding=0, m_axis_tvalid=0, credit_ok=1. Assert rst asynchronously during active popping -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared definitions for the 128-bit SM4 AXI-Stream datapath.
//   SM4_BLK_W          : width of one SM4 block on the stream
//   SM4_PIPE_LAT       : fixed latency of the SM4 core pipeline
//   SM4_EGRESS_MARGIN  : extra egress buffer slots beyond the pipeline depth
//   sm4_blk_t          : one buffered result, tlast kept alongside its data
package sm4_pkg;

  localparam int SM4_BLK_W         = 128;
  localparam int SM4_PIPE_LAT      = 32;
  localparam int SM4_EGRESS_MARGIN = 8;

  typedef struct packed {
    logic                 last;
    logic [SM4_BLK_W-1:0] data;
  } sm4_blk_t;

endpackage

// File: rtl/sm4_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous clear of pointers (wins over wr/rd)
//   wr, wdata     : write request and data; accepted when not full or
//                   when a read happens in the same cycle
//   rd            : read (pop) request; ignored when empty
//   rdata         : head entry, combinational from the storage array
//   full, empty   : occupancy flags
//   level         : occupancy, 0..2**AW
module sm4_fifo_fwft #(
  parameter int W  = 129,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_rd;
  logic         do_wr;

  // Pointers carry one extra bit so full and empty are distinguishable;
  // their difference is the occupancy directly.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A write into a full FIFO is still safe when the head is popped in the
  // same cycle: the slot being written is the one the read pointer leaves.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer registers; flush returns both to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/sm4_axis128_egress.sv
// Egress buffer for the SM4 AXI-Stream datapath. The core emits results
// without backpressure; this block stores them and presents an AXIS master
// to the consumer, and returns a credit so ingress only admits blocks whose
// result is guaranteed a buffer slot.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : synchronous clear on key/mode reload (keeps overflow)
//   in_fire         : one block admitted into the core this cycle
//   res_tvalid/tdata/tlast : core result stream (no backpressure)
//   m_axis_*        : buffered AXIS master towards the consumer
//   credit_ok       : ingress may accept another block
//   level           : FIFO occupancy
//   outstanding     : admitted blocks not yet popped
//   overflow        : sticky, a result arrived with no room to store it
module sm4_axis128_egress
  import sm4_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_fire,
  input  logic                 res_tvalid,
  input  logic [SM4_BLK_W-1:0] res_tdata,
  input  logic                 res_tlast,
  output logic [SM4_BLK_W-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 credit_ok,
  output logic [AW:0]          level,
  output logic [AW:0]          outstanding,
  output logic                 overflow
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  sm4_blk_t wr_blk;
  sm4_blk_t head_blk;
  logic     full;
  logic     empty;
  logic     pop;

  assign wr_blk.last = res_tlast;
  assign wr_blk.data = res_tdata;

  sm4_fifo_fwft #(
    .W  ($bits(sm4_blk_t)),
    .AW (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .wr    (res_tvalid),
    .wdata (wr_blk),
    .rd    (pop),
    .rdata (head_blk),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = head_blk.data;
  assign m_axis_tlast  = head_blk.last;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign credit_ok     = (outstanding < DEPTH_L);

  // Credit counter: admissions add, pops retire. Saturates at both ends so
  // a stray pulse can never wrap it and hand out phantom credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (flush) begin
      outstanding <= '0;
    end else begin
      case ({in_fire, pop})
        2'b10:   if (outstanding != DEPTH_L) outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0)      outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky overflow: a result that found the FIFO full with no pop to make
  // room was dropped. Only reset clears it so the event cannot be missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (!flush && res_tvalid && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sm4_axis128_egress.sv
module tb_sm4_axis128_egress;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_fire;
  logic         res_tvalid;
  logic [127:0] res_tdata;
  logic         res_tlast;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         credit_ok;
  logic [6:0]   level;
  logic [6:0]   outstanding;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [128:0] sb [$];

  always #5 clk = ~clk;

  sm4_axis128_egress #(.DEPTH(64), .AW(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_fire       (in_fire),
    .res_tvalid    (res_tvalid),
    .res_tdata     (res_tdata),
    .res_tlast     (res_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .credit_ok     (credit_ok),
    .level         (level),
    .outstanding   (outstanding),
    .overflow      (overflow)
  );

  // Drive the per-cycle inputs; called just after a rising edge.
  task automatic applyStimulus(input logic fire, input logic rv,
                               input logic [127:0] rd, input logic rl,
                               input logic fl);
    in_fire    = fire;
    res_tvalid = rv;
    res_tdata  = rd;
    res_tlast  = rl;
    flush      = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [128:0] obs,
                             input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: if a pop will happen at the next edge, compare the head
  // against the scoreboard, then advance to just after the edge.
  task automatic stepCycle();
    logic [128:0] exp;
    @(negedge clk);
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_pop observed=%0h expected=none",
               {m_axis_tlast, m_axis_tdata});
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checkOutput("pop_data", {m_axis_tlast, m_axis_tdata}, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_axis_tready = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    stepCycle();
    checkOutput("rst_tvalid", 129'(m_axis_tvalid), 129'(0));
    checkOutput("rst_level", 129'(level), 129'(0));
    checkOutput("rst_outstanding", 129'(outstanding), 129'(0));
    checkOutput("rst_credit", 129'(credit_ok), 129'(1));
    checkOutput("rst_overflow", 129'(overflow), 129'(0));
    checkOutput("rst_head", {m_axis_tlast, m_axis_tdata}, 129'(0));

    // 10 admissions, pipeline delay, then 10 results drained as they arrive
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("out10", 129'(outstanding), 129'(10));
    repeat (22) stepCycle();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 128'(i), (i == 10), 1'b0);
      sb.push_back({(i == 10), 128'(i)});
      stepCycle();
      checkOutput("lat1_tvalid", 129'(m_axis_tvalid), 129'(1));
      checkOutput("lat1_level", 129'(level), 129'(1));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("t2_outstanding", 129'(outstanding), 129'(0));
    checkOutput("t2_level", 129'(level), 129'(0));
    checkOutput("t2_tvalid", 129'(m_axis_tvalid), 129'(0));

    // Fill with tready low: credit drops after the 64th admission
    m_axis_tready = 1'b0;
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      stepCycle();
    end
    checkOutput("credit_at63", 129'(credit_ok), 129'(1));
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("credit_at64", 129'(credit_ok), 129'(0));
    checkOutput("out64", 129'(outstanding), 129'(64));
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 1'b1, 128'h100 + 128'(i), (i == 63), 1'b0);
      sb.push_back({(i == 63), 128'h100 + 128'(i)});
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_level", 129'(level), 129'(64));
    checkOutput("full_overflow", 129'(overflow), 129'(0));

    // Full FIFO, write and pop together: level holds, word stored
    m_axis_tready = 1'b1;
    applyStimulus(1'b0, 1'b1, 128'hBEEF, 1'b1, 1'b0);
    sb.push_back({1'b1, 128'hBEEF});
    stepCycle();
    checkOutput("wrpop_level", 129'(level), 129'(64));
    checkOutput("wrpop_overflow", 129'(overflow), 129'(0));

    // Full FIFO, no pop, extra result: dropped and overflow set
    m_axis_tready = 1'b0;
    applyStimulus(1'b0, 1'b1, 128'hDEAD, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("ovf_set", 129'(overflow), 129'(1));
    checkOutput("ovf_level", 129'(level), 129'(64));
    checkOutput("ovf_head", {m_axis_tlast, m_axis_tdata}, sb[0]);
    m_axis_tready = 1'b1;
    repeat (64) stepCycle();
    m_axis_tready = 1'b0;
    checkOutput("drain_level", 129'(level), 129'(0));
    checkOutput("drain_sb_empty", 129'(sb.size()), 129'(0));
    checkOutput("ovf_sticky", 129'(overflow), 129'(1));
    checkOutput("drain_outstanding", 129'(outstanding), 129'(0));

    // Flush with level 5 and outstanding 12
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, (i < 5), 128'h200 + 128'(i), 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("preflush_level", 129'(level), 129'(5));
    checkOutput("preflush_out", 129'(outstanding), 129'(12));
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush_level", 129'(level), 129'(0));
    checkOutput("flush_out", 129'(outstanding), 129'(0));
    checkOutput("flush_tvalid", 129'(m_axis_tvalid), 129'(0));
    checkOutput("flush_credit", 129'(credit_ok), 129'(1));
    checkOutput("flush_ovf_kept", 129'(overflow), 129'(1));

    // Async reset during active popping
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 128'h300 + 128'(i), 1'b0, 1'b0);
      sb.push_back({1'b0, 128'h300 + 128'(i)});
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("prerst_out", 129'(outstanding), 129'(1));
    checkOutput("prerst_tvalid", 129'(m_axis_tvalid), 129'(1));
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_tvalid", 129'(m_axis_tvalid), 129'(0));
    checkOutput("arst_level", 129'(level), 129'(0));
    checkOutput("arst_out", 129'(outstanding), 129'(0));
    checkOutput("arst_credit", 129'(credit_ok), 129'(1));
    checkOutput("arst_overflow", 129'(overflow), 129'(0));
    checkOutput("arst_head", {m_axis_tlast, m_axis_tdata}, 129'(0));
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
